uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 138 +++++++++++++
 tb/tb_uart_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte when idle, shifts it out LSB-first, one bit per SAMPLING_COUNTER_LIMIT baud ticks.
// Line drops to start one clock after accept; ready stays low until the last stop bit ends; valid while busy is ignored.
module uart_tx #(
  parameter int DATA_WIDTH             = 8,
  parameter int SAMPLING_COUNTER_LIMIT = 16,
  parameter int STOP_BITS              = 1
) (
  input  logic                  I_sys_clk,
  input  logic                  I_rst_n,
  input  logic                  I_baud_tick,
  input  logic [DATA_WIDTH-1:0] I_write_data,
  input  logic                  I_write_data_valid,
  output logic                  o_write_ready,
  output logic                  o_tx_serial_data,
  output logic                  o_tx_done
);

  localparam int TW = $clog2(SAMPLING_COUNTER_LIMIT);
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  assign bit_end = I_baud_tick && (tick_cnt_q == TW'(SAMPLING_COUNTER_LIMIT - 1));

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    done_d     = 1'b0;

    // Tick counter only advances inside a frame and wraps exactly at bit boundaries.
    if (state_q != IDLE && I_baud_tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (I_write_data_valid && ready_q) begin
          shift_d    = I_write_data;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b0;
          ready_d    = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            tx_d      = 1'b1;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_d[0];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            stop_cnt_d = 1'b0;
            done_d     = 1'b1;
            ready_d    = 1'b1;
            tx_d       = 1'b1;
            state_d    = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        tx_d       = 1'b1;
        ready_d    = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign o_write_ready    = ready_q;
  assign o_tx_serial_data = tx_q;
  assign o_tx_done        = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of single frames plus hand sequences for busy, back-to-back, reset abort and two stop bits.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [7:0] wdata, wdata2;
  logic       wvalid, wvalid2;
  logic       rdy, line, done;
  logic       rdy2, line2, done2;

  int div = 1;
  int pass_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(8), .SAMPLING_COUNTER_LIMIT(16), .STOP_BITS(1)) dut (
    .I_sys_clk(clk), .I_rst_n(rst_n), .I_baud_tick(tick),
    .I_write_data(wdata), .I_write_data_valid(wvalid),
    .o_write_ready(rdy), .o_tx_serial_data(line), .o_tx_done(done)
  );

  uart_tx #(.DATA_WIDTH(8), .SAMPLING_COUNTER_LIMIT(16), .STOP_BITS(2)) dut2 (
    .I_sys_clk(clk), .I_rst_n(rst_n), .I_baud_tick(tick),
    .I_write_data(wdata2), .I_write_data_valid(wvalid2),
    .o_write_ready(rdy2), .o_tx_serial_data(line2), .o_tx_done(done2)
  );

  // Baud tick: one pulse every div clocks, changed on the falling edge.
  initial begin
    int cnt;
    cnt  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (cnt >= div) cnt = 0;
      tick = (cnt == 0);
      cnt  = cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  typedef struct {
    logic [7:0] data;
    int         dv;
    logic [9:0] frame;  // time order: [0]=start, [8:1]=data LSB first, [9]=stop
    bit         poke;
    string      name;
  } vec_t;

  // Send one byte and check every bit at mid-bit, ready while busy, and the done pulse.
  task automatic run_frame(input vec_t v);
    int dc;
    int bad;
    div = v.dv;
    @(negedge clk);
    chk({v.name, "_pre_ready"}, 32'(rdy), 32'd1);
    wdata  = v.data;
    wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
    dc = -1;
    for (int c = 0; c <= 170 * v.dv; c++) begin
      if (c == 0) begin
        chk({v.name, "_start_line"}, 32'(line), 32'd0);
        chk({v.name, "_busy_ready"}, 32'(rdy), 32'd0);
      end
      if ((c % v.dv) == 0 && ((c / v.dv) % 16) == 8 && (c / v.dv) / 16 < 10)
        chk($sformatf("%s_bit%0d", v.name, (c / v.dv) / 16), 32'(line), 32'(v.frame[(c / v.dv) / 16]));
      if (c == 80 * v.dv) chk({v.name, "_mid_ready"}, 32'(rdy), 32'd0);
      if (v.poke && c == 40) begin wvalid = 1'b1; wdata = 8'hFF; end
      if (v.poke && c == 48) wvalid = 1'b0;
      if (done) begin dc = c; break; end
      @(negedge clk);
    end
    chk({v.name, "_done_time_ok"}, 32'(dc >= 159 * v.dv + 1 && dc <= 160 * v.dv), 32'd1);
    if (dc < 0) $display("FAIL %s_done_timeout: no done within %0d clocks", v.name, 170 * v.dv);
    chk({v.name, "_done_ready"}, 32'(rdy), 32'd1);
    chk({v.name, "_done_line"}, 32'(line), 32'd1);
    @(negedge clk);
    chk({v.name, "_done_1cyc"}, 32'(done), 32'd0);
    if (v.poke) begin
      bad = 0;
      for (int c = 0; c < 200; c++) begin
        if (line !== 1'b1 || rdy !== 1'b1 || done !== 1'b0) bad++;
        @(negedge clk);
      end
      chk({v.name, "_busy_req_ignored"}, 32'(bad), 32'd0);
    end
  endtask

  vec_t vecs[5];
  logic ln[0:340];
  logic dn[0:340];
  logic rd[0:340];

  initial begin
    logic [7:0] b;
    int npulse;
    int bad;

    vecs[0] = '{8'hA5, 1, 10'b1_10100101_0, 1'b0, "a5_t1"};
    vecs[1] = '{8'h01, 4, 10'b1_00000001_0, 1'b0, "01_t4"};
    vecs[2] = '{8'h3C, 1, 10'b1_00111100_0, 1'b1, "3c_busy"};
    vecs[3] = '{8'hFF, 2, 10'b1_11111111_0, 1'b0, "ff_t2"};
    vecs[4] = '{8'h00, 1, 10'b1_00000000_0, 1'b0, "00_t1"};

    rst_n   = 1'b0;
    wdata   = 8'h00;
    wvalid  = 1'b0;
    wdata2  = 8'h00;
    wvalid2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_line", 32'(line), 32'd1);
    chk("rst_ready", 32'(rdy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_line2", 32'(line2), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Back-to-back: valid held across frames, data switched after the first accept.
    div = 1;
    @(negedge clk);
    wdata  = 8'h55;
    wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wdata = 8'hAA;
    for (int c = 0; c <= 340; c++) begin
      ln[c] = line;
      dn[c] = done;
      if (c == 161) wvalid = 1'b0;
      @(negedge clk);
    end
    b = 8'h00;
    for (int j = 0; j < 8; j++) b[j] = ln[16 * (j + 1) + 8];
    chk("b2b_byte1", 32'(b), 32'h55);
    for (int j = 0; j < 8; j++) b[j] = ln[161 + 16 * (j + 1) + 8];
    chk("b2b_byte2", 32'(b), 32'hAA);
    chk("b2b_done1", 32'(dn[160]), 32'd1);
    chk("b2b_gap_line", 32'(ln[160]), 32'd1);
    chk("b2b_start2", 32'(ln[161]), 32'd0);
    chk("b2b_done2", 32'(dn[321]), 32'd1);
    npulse = 0;
    for (int c = 0; c <= 340; c++) if (dn[c] === 1'b1) npulse++;
    chk("b2b_npulse", 32'(npulse), 32'd2);
    chk("b2b_idle_after", 32'(ln[340]), 32'd1);

    // Reset during data bit 3 of 0x0F.
    @(negedge clk);
    wdata  = 8'h0F;
    wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
    repeat (70) @(negedge clk);
    chk("rst_mid_bit3", 32'(line), 32'd1);
    chk("rst_mid_busy", 32'(rdy), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_line", 32'(line), 32'd1);
    chk("rst_async_ready", 32'(rdy), 32'd1);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || line !== 1'b1) bad++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || line !== 1'b1) bad++;
    end
    chk("rst_no_done", 32'(bad), 32'd0);
    run_frame('{8'h81, 1, 10'b1_10000001_0, 1'b0, "81_after_rst"});

    // Two stop bits on the second instance.
    div = 1;
    @(negedge clk);
    wdata2  = 8'h00;
    wvalid2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wvalid2 = 1'b0;
    for (int c = 0; c <= 200; c++) begin
      ln[c] = line2;
      dn[c] = done2;
      rd[c] = rdy2;
      @(negedge clk);
    end
    chk("s2_start", 32'(ln[8]), 32'd0);
    chk("s2_bit7", 32'(ln[136]), 32'd0);
    chk("s2_stop1", 32'(ln[152]), 32'd1);
    chk("s2_stop2", 32'(ln[168]), 32'd1);
    chk("s2_no_done_160", 32'(dn[160]), 32'd0);
    chk("s2_ready_175", 32'(rd[175]), 32'd0);
    chk("s2_done_176", 32'(dn[176]), 32'd1);
    chk("s2_ready_176", 32'(rd[176]), 32'd1);
    npulse = 0;
    for (int c = 0; c <= 200; c++) if (dn[c] === 1'b1) npulse++;
    chk("s2_npulse", 32'(npulse), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
